mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 512-word RAM between two requesters: the CPU memory path (MAR/MDR, driven by control_unit Read/Write) and a debug/program-loader port.
- Fixed 3-state transaction sequencer with 2-way round-robin arbitration, plus a debug hold that freezes CPU memory traffic while the loader owns memory.
- Sits between the datapath's memory registers and the RAM instance.

Parameters:
ADDR_W, 9, RAM address width (word-addressed)
DATA_W, 32, data width

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  asynchronous active-high reset
cpu_req  in  1  CPU request; held with we/addr/wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data holding register
cpu_ack  out  1  one-cycle completion pulse
dbg_req  in  1  debug request, same rules as cpu_req
dbg_we  in  1  debug write select
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  debug read data holding register
dbg_ack  out  1  one-cycle completion pulse
dbg_hold  in  1  1 = CPU requests are not granted
mem_read  out  1  RAM read strobe
mem_write  out  1  RAM write strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_read
busy  out  1  state != IDLE
owner  out  1  0 = CPU, 1 = debug; owner of current/last transaction

Behaviour:
- Reset (clear=1, asynchronous): state IDLE; mem_read, mem_write, cpu_ack, dbg_ack, busy = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; owner = 1, so the CPU wins the first tie.
- Clear mid-transaction aborts the transaction: no ack is issued, and the RAM strobe drops immediately.
- States: IDLE, ACCESS, RESP.
- Eligibility: cpu_elig = cpu_req & ~dbg_hold; dbg_elig = dbg_req.
- IDLE:
  - Only one port eligible: grant it.
  - Both eligible: grant the port != owner (round-robin).
  - On grant, register we/addr/wdata into mem_* and owner, then go to ACCESS.
  - No eligible port: stay in IDLE.
- ACCESS (1 cycle):
  - mem_read = ~we or mem_write = we, driven from registers.
  - mem_addr/mem_wdata are stable for the whole cycle.
  - Next state RESP.
- RESP (1 cycle):
  - Strobes are 0; ack pulses to the owner only.
  - For a read, the owner's rdata register captures mem_rdata at the end of this cycle. It is visible the cycle after ack, and held until that port's next read completes.
  - Exception: so that rdata is valid with ack, the capture occurs at the ACCESS->RESP edge using a registered-output RAM, and rdata is valid during the ack cycle.
  - For a write, rdata is unchanged.
  - The other port eligible in RESP: grant it directly (RESP->ACCESS, bypassing IDLE).
  - The owner's own req is ignored in RESP, because it is still the current transaction.
  - Otherwise go to IDLE.
- Latency:
  - Uncontested request: 3 cycles req-to-ack (IDLE, ACCESS, RESP).
  - Contested loser: ack 2 cycles after the winner's ack.
- Requester rule: req deasserts, or changes fields, only after sampling ack. Req still high in IDLE after ack means a new transaction.
- dbg_hold:
  - Asserted during a CPU ACCESS/RESP: the transaction completes normally.
  - No new CPU grant while it is high.
  - The CPU request stays pending and is granted in the first IDLE/RESP cycle after hold drops.
- Simultaneous cpu_req and dbg_req every cycle: grants strictly alternate.
- No starvation: max wait is one transaction.
- Address width: mem_addr is exactly ADDR_W. No wrap or range check; the requester truncates.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - OWNER_CPU=1'b0, OWNER_DBG=1'b1
  - ADDR_W/DATA_W defaults
- One sub-module, rr_pick2: combinational 2-way round-robin picker (inputs: two elig bits and last owner; outputs: grant_valid, grant_id). Everything else lives in mem_port_arbiter.

Test Plan:
- Reset, then a single CPU write: addr 0x05, data 0xDEADBEEF → mem_write high in cycle 1 with addr 0x05, cpu_ack in cycle 2. A following CPU read of 0x05 returns cpu_rdata=0xDEADBEEF with its ack.
- Both request in the same IDLE cycle after reset → CPU granted first. The debug access goes RESP->ACCESS with no IDLE gap, and dbg_ack is 2 cycles after cpu_ack.
- Both held high for 6 transactions → owner sequence 0,1,0,1,0,1 with an ack every 2 cycles.
- dbg_hold=1 with cpu_req held for 10 cycles while debug writes 0x00..0x03 → no cpu_ack. Hold drops, then cpu_ack follows within 3 cycles.
- dbg_hold raised during a CPU ACCESS → that CPU transaction still acks, and no later CPU grant occurs while hold is high.
- clear pulsed during ACCESS of a debug read → strobes drop immediately, no dbg_ack, state IDLE, owner=1, dbg_rdata=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, owner ids and width defaults for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; a tie goes to the port that did not own last
module rr_pick2 import mem_arb_pkg::*; (
    input  logic cpu_elig_i,
    input  logic dbg_elig_i,
    input  logic last_owner_i,
    output logic grant_valid_o,
    output logic grant_id_o
);
    assign grant_valid_o = cpu_elig_i | dbg_elig_i;
    assign grant_id_o    = (cpu_elig_i & dbg_elig_i) ? ~last_owner_i : (dbg_elig_i ? OWNER_DBG : OWNER_CPU);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM between the CPU memory path and a debug/loader port
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    input  logic              dbg_hold,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              pick_cpu, pick_dbg, grant_valid, grant_id, rd_cap;

    // In RESP only the non-owner may be granted; the owner's req is still the finishing transaction
    assign pick_cpu = cpu_req & ~dbg_hold & (state_q == IDLE | (state_q == RESP & owner_q == OWNER_DBG));
    assign pick_dbg = dbg_req & (state_q == IDLE | (state_q == RESP & owner_q == OWNER_CPU));

    rr_pick2 u_pick (
        .cpu_elig_i   (pick_cpu),
        .dbg_elig_i   (pick_dbg),
        .last_owner_i (owner_q),
        .grant_valid_o(grant_valid),
        .grant_id_o   (grant_id)
    );

    // Registered-output RAM data is sampled at the ACCESS->RESP edge so rdata is valid with ack
    assign rd_cap = state_q == ACCESS & ~we_q;

    always_comb begin
        state_d     = grant_valid ? ACCESS : (state_q == ACCESS ? RESP : IDLE);
        owner_d     = grant_valid ? grant_id : owner_q;
        we_d        = grant_valid ? (grant_id ? dbg_we : cpu_we) : we_q;
        addr_d      = grant_valid ? (grant_id ? dbg_addr : cpu_addr) : addr_q;
        wdata_d     = grant_valid ? (grant_id ? dbg_wdata : cpu_wdata) : wdata_q;
        cpu_rdata_d = (rd_cap & owner_q == OWNER_CPU) ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d = (rd_cap & owner_q == OWNER_DBG) ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_read  = state_q == ACCESS & ~we_q;
    assign mem_write = state_q == ACCESS & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = state_q == RESP & owner_q == OWNER_CPU;
    assign dbg_ack   = state_q == RESP & owner_q == OWNER_DBG;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = state_q != IDLE;
    assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, hold, latency and abort behaviour
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        clear;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_hold;
    logic [8:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, dbg_ack, mem_read, mem_write, busy, owner;
    logic [31:0] ram [0:511];
    int          vec = 0;
    int          miss = 0;

    mem_port_arbiter dut (
        .clock(clock), .clear(clear),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_hold(dbg_hold),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_write) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        #2;
        clear = 1'b0;
        step();
    endtask

    task automatic test_reset;
        clear = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_hold = 0;
        step();
        step();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b exp 0", busy); end
        vec++; if (owner !== 1'b1) begin miss++; $display("FAIL reset_owner got %b exp 1", owner); end
        vec++; if ({mem_read, mem_write, cpu_ack, dbg_ack} !== 4'b0000) begin miss++; $display("FAIL reset_strobes got %b exp 0000", {mem_read, mem_write, cpu_ack, dbg_ack}); end
        vec++; if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== '0) begin miss++; $display("FAIL reset_regs got %h %h %h %h exp 0", mem_addr, mem_wdata, cpu_rdata, dbg_rdata); end
        clear = 1'b0;
        step();
    endtask

    task automatic test_cpu_write_read;
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
        step();
        vec++; if ({mem_write, mem_read, cpu_ack} !== 3'b100) begin miss++; $display("FAIL wr_access_strobes got %b exp 100", {mem_write, mem_read, cpu_ack}); end
        vec++; if (mem_addr !== 9'h005 || mem_wdata !== 32'hDEADBEEF) begin miss++; $display("FAIL wr_access_bus got %h %h exp 005 deadbeef", mem_addr, mem_wdata); end
        step();
        vec++; if ({cpu_ack, dbg_ack, mem_write, owner} !== 4'b1000) begin miss++; $display("FAIL wr_resp got %b exp 1000", {cpu_ack, dbg_ack, mem_write, owner}); end
        cpu_req = 0;
        step();
        vec++; if ({busy, cpu_ack} !== 2'b00) begin miss++; $display("FAIL wr_idle got %b exp 00", {busy, cpu_ack}); end
        cpu_req = 1; cpu_we = 0;
        step();
        vec++; if ({mem_read, mem_write} !== 2'b10) begin miss++; $display("FAIL rd_access got %b exp 10", {mem_read, mem_write}); end
        step();
        vec++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin miss++; $display("FAIL rd_resp got ack %b data %h exp 1 deadbeef", cpu_ack, cpu_rdata); end
        cpu_req = 0;
        step();
    endtask

    task automatic test_contest;
        do_clear();
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'h11111111;
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h011; dbg_wdata = 32'h22222222;
        step();
        vec++; if (owner !== 1'b0 || mem_addr !== 9'h010 || mem_write !== 1'b1) begin miss++; $display("FAIL contest_first got owner %b addr %h wr %b exp 0 010 1", owner, mem_addr, mem_write); end
        step();
        vec++; if ({cpu_ack, dbg_ack} !== 2'b10) begin miss++; $display("FAIL contest_cpu_ack got %b exp 10", {cpu_ack, dbg_ack}); end
        cpu_req = 0;
        step();
        vec++; if ({busy, owner, mem_write} !== 3'b111 || mem_addr !== 9'h011) begin miss++; $display("FAIL contest_no_gap got %b addr %h exp 111 011", {busy, owner, mem_write}, mem_addr); end
        vec++; if (dbg_ack !== 1'b0) begin miss++; $display("FAIL contest_dbg_early got %b exp 0", dbg_ack); end
        step();
        vec++; if ({cpu_ack, dbg_ack} !== 2'b01) begin miss++; $display("FAIL contest_dbg_ack got %b exp 01", {cpu_ack, dbg_ack}); end
        dbg_req = 0;
        step();
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL contest_idle got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        do_clear();
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h011;
        for (int i = 0; i < 6; i++) begin
            step();
            vec++; if (owner !== i[0] || mem_read !== 1'b1) begin miss++; $display("FAIL b2b_owner%0d got %b rd %b exp %b 1", i, owner, mem_read, i[0]); end
            step();
            vec++; if ({cpu_ack, dbg_ack} !== (i[0] ? 2'b01 : 2'b10)) begin miss++; $display("FAIL b2b_ack%0d got %b exp %b", i, {cpu_ack, dbg_ack}, i[0] ? 2'b01 : 2'b10); end
        end
        cpu_req = 0; dbg_req = 0;
        vec++; if (cpu_rdata !== 32'h11111111 || dbg_rdata !== 32'h22222222) begin miss++; $display("FAIL b2b_rdata got %h %h exp 11111111 22222222", cpu_rdata, dbg_rdata); end
        step();
    endtask

    task automatic test_hold;
        logic got;
        dbg_hold = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h020; cpu_wdata = 32'h33333333;
        for (int i = 0; i < 4; i++) begin
            dbg_req = 1; dbg_we = 1; dbg_addr = 9'(i); dbg_wdata = 32'h100 + i;
            step();
            vec++; if (owner !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 9'(i) || mem_wdata !== 32'h100 + i) begin miss++; $display("FAIL hold_dbg_wr%0d got owner %b wr %b addr %h data %h", i, owner, mem_write, mem_addr, mem_wdata); end
            step();
            vec++; if ({dbg_ack, cpu_ack} !== 2'b10) begin miss++; $display("FAIL hold_ack%0d got %b exp 10", i, {dbg_ack, cpu_ack}); end
            dbg_req = 0;
            step();
            vec++; if ({busy, cpu_ack} !== 2'b00) begin miss++; $display("FAIL hold_blocked%0d got %b exp 00", i, {busy, cpu_ack}); end
        end
        dbg_hold = 0;
        got = 0;
        for (int k = 0; k < 3 && !got; k++) begin
            step();
            got = cpu_ack;
        end
        vec++; if (got !== 1'b1) begin miss++; $display("FAIL hold_release got %b exp 1", got); end
        cpu_req = 0;
        step();
    endtask

    task automatic test_hold_mid;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h001;
        step();
        vec++; if (owner !== 1'b0 || mem_read !== 1'b1) begin miss++; $display("FAIL holdmid_access got %b %b exp 0 1", owner, mem_read); end
        dbg_hold = 1;
        step();
        vec++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h101) begin miss++; $display("FAIL holdmid_ack got %b %h exp 1 00000101", cpu_ack, cpu_rdata); end
        for (int i = 0; i < 4; i++) begin
            step();
            vec++; if ({busy, cpu_ack, mem_read} !== 3'b000) begin miss++; $display("FAIL holdmid_nogrant%0d got %b exp 000", i, {busy, cpu_ack, mem_read}); end
        end
        cpu_req = 0; dbg_hold = 0;
        step();
    endtask

    task automatic test_clear_abort;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h002;
        step();
        vec++; if (mem_read !== 1'b1 || owner !== 1'b1) begin miss++; $display("FAIL abort_access got %b %b exp 1 1", mem_read, owner); end
        clear = 1;
        #1;
        vec++; if ({mem_read, mem_write, busy, dbg_ack} !== 4'b0000) begin miss++; $display("FAIL abort_drop got %b exp 0000", {mem_read, mem_write, busy, dbg_ack}); end
        vec++; if (owner !== 1'b1 || dbg_rdata !== 32'h0 || mem_addr !== 9'h0) begin miss++; $display("FAIL abort_regs got %b %h %h exp 1 0 0", owner, dbg_rdata, mem_addr); end
        dbg_req = 0;
        clear = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            vec++; if ({dbg_ack, busy} !== 2'b00) begin miss++; $display("FAIL abort_noack%0d got %b exp 00", i, {dbg_ack, busy}); end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_contest();
        test_back_to_back();
        test_hold();
        test_hold_mid();
        test_clear_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
